// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths for the shared-multiplier scheduler
package mult_pkg;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// rtl/mult_share_sched_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  gid
);

    int idx;

    // Scan from the farthest offset down so the one closest to ptr wins last.
    always_comb begin
        grant = '0;
        gid   = '0;
        idx   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                gid        = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/radix_4_8x8.sv
// rtl/radix_4_8x8.sv - combinational radix-4 Booth 8x8 signed multiplier
module Radix_4_8x8
    import mult_pkg::*;
(
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    output logic [PROD_W-1:0] z
);

    logic [PROD_W-1:0] xe;
    logic [OP_W:0]     ye;
    logic [PROD_W-1:0] pp [4];
    logic [PROD_W-1:0] sa, ca, sb, cb;
    logic [PROD_W:0]   carry;

    assign xe = {{(PROD_W-OP_W){x[OP_W-1]}}, x};
    assign ye = {y, 1'b0};

    // One Booth digit per overlapping 3-bit window of {y, 0}.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            pp[j] = '0;
            case (ye[2*j +: 3])
                3'b001, 3'b010: pp[j] = xe;
                3'b011:         pp[j] = xe << 1;
                3'b100:         pp[j] = -(xe << 1);
                3'b101, 3'b110: pp[j] = -xe;
                default:        pp[j] = '0;
            endcase
            pp[j] = pp[j] << (2*j);
        end
    end

    assign sa = pp[0] ^ pp[1] ^ pp[2];
    assign ca = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    assign sb = sa ^ ca ^ pp[3];
    assign cb = ((sa & ca) | (sa & pp[3]) | (ca & pp[3])) << 1;

    assign carry[0] = 1'b0;
    for (genvar i = 0; i < PROD_W; i++) begin : g_ripple
        assign z[i]       = sb[i] ^ cb[i] ^ carry[i];
        assign carry[i+1] = (sb[i] & cb[i]) | (sb[i] & carry[i]) | (cb[i] & carry[i]);
    end

endmodule

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin sharing of one Booth multiplier, 2-stage pipeline
module mult_share_sched
    import mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [OP_W*N_REQ-1:0] req_x,
    input  logic [OP_W*N_REQ-1:0] req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [PROD_W-1:0]     rsp_prod,
    output logic [ID_W-1:0]       rsp_id
);

    logic [ID_W-1:0]   rr_ptr, gid;
    logic [N_REQ-1:0]  grant;
    logic              s1_valid, s2_valid;
    logic [OP_W-1:0]   s1_x, s1_y;
    logic [ID_W-1:0]   s1_id, s2_id;
    logic [PROD_W-1:0] s2_prod, mul_p;
    logic              s1_adv, s2_adv, accept;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .gid   (gid)
    );

    Radix_4_8x8 u_mul (
        .x (s1_x),
        .y (s1_y),
        .z (mul_p)
    );

    assign s2_adv    = !s2_valid | rsp_ready;
    assign s1_adv    = !s1_valid | s2_adv;
    // rst gating keeps req_ready low during reset even though S1 looks empty.
    assign req_ready = rst ? '0 : (grant & {N_REQ{s1_adv}});
    assign accept    = |req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_id    <= '0;
        end else begin
            if (s1_adv) s1_valid <= accept;
            if (accept) begin
                s1_x   <= req_x[gid*OP_W +: OP_W];
                s1_y   <= req_y[gid*OP_W +: OP_W];
                s1_id  <= gid;
                rr_ptr <= (int'(gid) == N_REQ - 1) ? '0 : gid + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_id    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            s2_prod  <= mul_p;
            s2_id    <= s1_id;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_prod  = s2_prod;
    assign rsp_id    = s2_id;

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - scoreboard bench for mult_share_sched
module tb_mult_share_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_x, req_y;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_prod;
    logic [1:0]  rsp_id;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] prod;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  acc_ids[$];
    logic [15:0] got[$];
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  last_ready;
    logic        last_rsp_valid;
    logic [15:0] last_prod, held_prod;
    logic [1:0]  last_id;

    mult_share_sched #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        int a, b;
        a = int'($signed(x));
        b = int'($signed(y));
        return 16'(a * b);
    endfunction

    task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[8*i +: 8] = x;
        req_y[8*i +: 8] = y;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        exp_t e;
        #1;
        last_ready     = req_ready;
        last_rsp_valid = rsp_valid;
        last_prod      = rsp_prod;
        last_id        = rsp_id;
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb.push_back('{id: 2'(i), prod: model(req_x[8*i +: 8], req_y[8*i +: 8])});
                acc_ids.push_back(2'(i));
            end
        end
        if (rsp_valid && rsp_ready) begin
            got.push_back(rsp_prod);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_prod", 32'(rsp_prod), 32'(e.prod));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        logic [7:0] cx [4];
        logic [7:0] cy [4];
        logic [15:0] cp [4];
        cx = '{8'h80, 8'hFF, 8'h80, 8'h00};
        cy = '{8'h80, 8'h7F, 8'h7F, 8'hF9};
        cp = '{16'h4000, 16'hFF81, 16'hC080, 16'h0000};

        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_x = '0; req_y = '0;
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = '0;

        // single operation from requester 2
        set_op(2, 8'd3, 8'd5);
        req_valid = 4'b0100;
        step();
        chk("single_accept", 32'(last_ready), 32'h4);
        req_valid = '0;
        step();
        chk("single_lat1", 32'(last_rsp_valid), 32'd0);
        step();
        chk("single_lat2", 32'(last_rsp_valid), 32'd1);
        chk("single_prod", 32'(last_prod), 32'h000F);
        chk("single_id", 32'(last_id), 32'd2);
        step();
        chk("single_drained", 32'(sb.size()), 32'd0);

        // signed corners
        got.delete();
        for (int k = 0; k < 4; k++) begin
            set_op(0, cx[k], cy[k]);
            req_valid = 4'b0001;
            step();
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        chk("corner_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) chk("corner_prod", 32'(got[k]), 32'(cp[k]));

        // fairness with all requesters active
        do_reset();
        acc_ids.delete(); got.delete();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) set_op(i, 8'($urandom), 8'($urandom));
            step();
            if (k >= 2) chk("fair_rsp_each_cycle", 32'(last_rsp_valid), 32'd1);
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        chk("fair_acc_count", 32'(acc_ids.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < acc_ids.size()) chk("fair_order", 32'(acc_ids[k]), 32'(k % 4));
        chk("fair_rsp_count", 32'(got.size()), 32'd8);

        // backpressure
        acc_ids.delete();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        held_prod = '0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) set_op(i, 8'($urandom), 8'($urandom));
            step();
            if (k == 2) held_prod = last_prod;
            if (k >= 2) begin
                chk("bp_ready_zero", 32'(last_ready), 32'd0);
                chk("bp_rsp_valid", 32'(last_rsp_valid), 32'd1);
                chk("bp_prod_stable", 32'(last_prod), 32'(held_prod));
            end
        end
        chk("bp_accepted", 32'(acc_ids.size()), 32'd2);
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 4; k++) step();
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // reset with two operations in flight
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        sb.delete(); got.delete();
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        step();
        chk("midrst_first_grant", 32'(last_ready), 32'h2);
        req_valid = '0;
        for (int k = 0; k < 4; k++) step();
        chk("midrst_rsp_count", 32'(got.size()), 32'd1);
        chk("midrst_drained", 32'(sb.size()), 32'd0);

        // sparse requests and pointer wrap
        do_reset();
        req_valid = 4'b1000; step();
        chk("sparse_g3", 32'(last_ready), 32'h8);
        req_valid = 4'b0011; step();
        chk("sparse_wrap_g0", 32'(last_ready), 32'h1);
        req_valid = 4'b0010; step();
        chk("sparse_g1", 32'(last_ready), 32'h2);
        req_valid = 4'b0101; step();
        chk("sparse_g2", 32'(last_ready), 32'h4);
        req_valid = '0;
        for (int k = 0; k < 4; k++) step();
        chk("sparse_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
